// File: rtl/shot_pkg.sv
// Shared types and default constants for the shot_select front end.
// Phase encoding matches the value shown on the debug/display phase output.
package shot_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        AIM   = 3'd1,
        POWER = 3'd2,
        FIRE  = 3'd3,
        DONE  = 3'd4
    } phase_e;

    localparam int unsigned TICK_DIV_DEF   = 16;
    localparam int unsigned ANGLE_STEP_DEF = 5;
    localparam int unsigned ANGLE_MAX_DEF  = 90;
    localparam int unsigned STR_STEP_DEF   = 1;
    localparam int unsigned STR_MAX_DEF    = 127;

    // Tick counter width; a divider of 1 still needs a one-bit register.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/shot_select_if.sv
// Player-side bundle: the button going in, the aiming operands and status coming out.
// The shot_select block uses the slave view; whoever drives the button uses master.
interface shot_select_if;

    logic       btn;
    logic [7:0] angle;
    logic [7:0] strength;
    logic       fire;
    logic [2:0] phase;
    logic       busy;

    modport master (
        output btn,
        input  angle,
        input  strength,
        input  fire,
        input  phase,
        input  busy
    );

    modport slave (
        input  btn,
        output angle,
        output strength,
        output fire,
        output phase,
        output busy
    );

endinterface

// File: rtl/shot_select_pingpong_counter.sv
// Bounded up/down sweep over 0..MAX in steps of STEP, reversing at either end.
// At an end the value bounces straight to the neighbouring step rather than dwelling.
module pingpong_counter
    import shot_pkg::*;
#(
    parameter int unsigned STEP = ANGLE_STEP_DEF,
    parameter int unsigned MAX  = ANGLE_MAX_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [7:0] value
);

    localparam logic [7:0] C_STEP = 8'(STEP);
    localparam logic [7:0] C_MAX  = 8'(MAX);
    localparam logic [7:0] C_TOP  = 8'(MAX - STEP);

    logic [7:0] r_value;
    logic       r_dir_down;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            r_value    <= 8'd0;
            r_dir_down <= 1'b0;
        end else if (en) begin
            if (!r_dir_down) begin
                if (r_value == C_MAX) begin
                    r_dir_down <= 1'b1;
                    r_value    <= C_TOP;
                end else begin
                    r_value <= r_value + C_STEP;
                end
            end else begin
                if (r_value == 8'd0) begin
                    r_dir_down <= 1'b0;
                    r_value    <= C_STEP;
                end else begin
                    r_value <= r_value - C_STEP;
                end
            end
        end
    end

    assign value = r_value;

endmodule

// File: rtl/shot_select.sv
// Single-button aim/power/fire sequencer feeding angle and strength to the score stage.
// Outputs come straight from registers, so btn never reaches an output combinationally.
module shot_select
    import shot_pkg::*;
#(
    parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
    parameter int unsigned ANGLE_STEP = ANGLE_STEP_DEF,
    parameter int unsigned ANGLE_MAX  = ANGLE_MAX_DEF,
    parameter int unsigned STR_STEP   = STR_STEP_DEF,
    parameter int unsigned STR_MAX    = STR_MAX_DEF
) (
    input  logic         clk,
    input  logic         reset,
    shot_select_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'(IDLE);
    localparam logic [2:0] S_AIM   = 3'(AIM);
    localparam logic [2:0] S_POWER = 3'(POWER);
    localparam logic [2:0] S_FIRE  = 3'(FIRE);
    localparam logic [2:0] S_DONE  = 3'(DONE);

    localparam int unsigned     CW       = cnt_width(TICK_DIV);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TICK_DIV - 1);

    logic [2:0]    r_state;
    logic          r_btn_q;
    logic [CW-1:0] r_cnt;

    logic       w_press;
    logic       w_sweep;
    logic       w_tick;
    logic       w_clr;
    logic       w_angle_en;
    logic       w_str_en;
    logic [7:0] w_angle;
    logic [7:0] w_strength;

    assign w_press = bus.btn & ~r_btn_q;
    assign w_sweep = (r_state == S_AIM) || (r_state == S_POWER);
    assign w_tick  = w_sweep && (r_cnt == CNT_LAST);

    // A press on a tick edge wins: the operand freezes at its pre-tick value.
    assign w_angle_en = (r_state == S_AIM)   && w_tick && !w_press;
    assign w_str_en   = (r_state == S_POWER) && w_tick && !w_press;
    assign w_clr      = (r_state == S_IDLE) || ((r_state == S_DONE) && w_press);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_btn_q <= 1'b0;
        end else begin
            r_btn_q <= bus.btn;
        end
    end

    // Leaving a sweep phase or pressing always restarts the divider from zero.
    always_ff @(posedge clk) begin
        if (!reset || !w_sweep || w_press) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_press) r_state <= S_AIM;
                S_AIM:   if (w_press) r_state <= S_POWER;
                S_POWER: if (w_press) r_state <= S_FIRE;
                S_FIRE:  r_state <= S_DONE;
                S_DONE:  if (w_press) r_state <= S_AIM;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    pingpong_counter #(
        .STEP (ANGLE_STEP),
        .MAX  (ANGLE_MAX)
    ) u_angle (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .en    (w_angle_en),
        .value (w_angle)
    );

    pingpong_counter #(
        .STEP (STR_STEP),
        .MAX  (STR_MAX)
    ) u_strength (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .en    (w_str_en),
        .value (w_strength)
    );

    assign bus.angle    = w_angle;
    assign bus.strength = w_strength;
    assign bus.phase    = r_state;
    assign bus.fire     = (r_state == S_FIRE);
    assign bus.busy     = (r_state == S_AIM) || (r_state == S_POWER) || (r_state == S_FIRE);

endmodule

// File: doc/shot_select.md
Name: shot_select

Overview:
- Player-input front end that generates the `angle` and `strength` operands consumed by the score stage.
- Single button, three phases: sweep angle, sweep strength, fire.
- On fire, emits a one-cycle `fire` pulse and holds `angle`/`strength` stable so the score stage samples valid operands.
- Sits between the debounced button synchroniser and the score stage.

Parameters:
- TICK_DIV, 16: clock cycles per sweep step; minimum 1.
- ANGLE_STEP, 5: angle increment per tick, in degrees.
- ANGLE_MAX, 90: upper angle bound, in degrees; must be a multiple of ANGLE_STEP.
- STR_STEP, 1: strength increment per tick.
- STR_MAX, 127: upper strength bound; must be a multiple of STR_STEP. Kept ≤127 so that strength*2 in the score stage fits 8 bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- btn  in  1  debounced, clk-synchronous player button, level-sensitive.
- angle  out  8  current or locked angle, in degrees.
- strength  out  8  current or locked strength.
- fire  out  1  one-cycle pulse; operands are valid and frozen while it is high.
- phase  out  3  FSM state, for display/debug.
- busy  out  1  high in AIM, POWER and FIRE.

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE, angle=0, strength=0, fire=0, busy=0, tick counter=0, btn_q=0, both sweep directions=up. Reset mid-operation aborts any phase; there is no partial-reset state.
- Press detection:
  - btn_q registers btn each cycle.
  - press = btn & ~btn_q.
  - A held button produces exactly one press; release has no effect.
- Tick counter:
  - Runs only in AIM and POWER; counts 0..TICK_DIV-1.
  - tick = (cnt == TICK_DIV-1). The counter wraps to 0 on tick.
  - Cleared to 0 on entry to AIM and to POWER.
- State machine (one transition per edge):
  - IDLE: angle=0, strength=0. press -> AIM.
  - AIM: on tick, angle steps by ANGLE_STEP, ping-pong.
    - Direction up: at ANGLE_MAX, direction flips and the value becomes ANGLE_MAX-ANGLE_STEP.
    - Direction down: at 0, direction flips and the value becomes ANGLE_STEP.
    - press -> POWER; angle frozen from then on.
  - POWER: strength ping-pongs over 0..STR_MAX by STR_STEP, using the same rules as angle. press -> FIRE; strength frozen.
  - FIRE: fire=1 for exactly this one cycle, then -> DONE unconditionally. A press during FIRE is ignored.
  - DONE: angle and strength held, fire=0. press -> AIM with angle=0, strength=0, both directions=up, cnt=0.
- Simultaneous press and tick in AIM/POWER: the press wins. The value is frozen at its pre-tick value and no step occurs.
- Latency: the press that is sampled at edge N produces phase change at edge N. fire is high during the cycle following the third press.
- Arithmetic: all values are 8-bit unsigned. By the parameter constraints, no intermediate value exceeds 255 or goes below 0.
- Outputs are registered; no combinational path from btn to any output.
- Encoding: phase uses IDLE=0, AIM=1, POWER=2, FIRE=3, DONE=4.

Decomposition:
- Shared package shot_pkg holds:
  - the phase enum (IDLE/AIM/POWER/FIRE/DONE);
  - ANGLE_MAX_DEF=90 and ANGLE_STEP_DEF=5;
  - STR_MAX_DEF=127.
- Sub-module pingpong_counter, instantiated twice (angle and strength):
  - parameters STEP, MAX;
  - inputs clk, reset, clr, en;
  - output 8-bit value;
  - internal direction bit.
- The top level contains the FSM, press detect and tick counter.

Test Plan (TICK_DIV=4 unless noted):
- Reset: drive reset=0 for 2 cycles while in POWER -> angle=0, strength=0, phase=IDLE, fire=0, busy=0.
- Aim sweep: press, wait 12 cycles (3 ticks), press -> angle locked at 15 and unchanged for 50 cycles; phase=POWER.
- Angle wrap: press, then 18 ticks -> angle=90; tick 19 -> 85; after 36 ticks total -> 0, then 5 on tick 37.
- Strength and fire:
  - lock angle 40, then 127 ticks -> strength=127; next tick -> 126;
  - press -> fire high exactly one cycle, angle=40, strength=126 held through DONE.
- Press/tick collision: press asserted on the cycle where cnt==3 in AIM with angle=10 -> angle stays 10, phase=POWER.
- Held button: btn held high for 100 cycles from IDLE -> a single transition to AIM only, sweep proceeds, no further phase changes until release and re-press.
